// File: rtl/corr_ctrl_pkg.sv
// Shared types and helpers for the correlator stage controller.
package corr_ctrl_pkg;

    // State encodings, kept separate so they can be referenced by name.
    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_CLEAR = 3'd1;
    localparam logic [2:0] ENC_FILL  = 3'd2;
    localparam logic [2:0] ENC_INTEG = 3'd3;
    localparam logic [2:0] ENC_DUMP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_CLEAR = ENC_CLEAR,
        ST_FILL  = ENC_FILL,
        ST_INTEG = ENC_INTEG,
        ST_DUMP  = ENC_DUMP
    } state_t;

    // Smallest w with 2**w >= value.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Fill counter must hold 0..depth; never narrower than one bit.
    function automatic int fill_width(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

endpackage

// File: rtl/corr_sample_counter.sv
// Sample counter with enable, synchronous zero and a terminal flag that
// fires when the next enabled increment would reach the loaded limit.
module corr_sample_counter
    import corr_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         last
);

    logic [W-1:0] count_reg;
    logic [W:0]   count_inc;

    // One extra bit so the compare is exact even for limit = 2**W-1.
    assign count_inc = {1'b0, count_reg} + {{W{1'b0}}, 1'b1};
    assign last      = (count_inc == {1'b0, limit});

    // Count accepted samples; a clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_inc[W-1:0];
        end
    end

endmodule

// File: rtl/corr_stage_ctrl.sv
// Sequencing controller for one correlator stage: clear, prime the delay
// lines, integrate a programmed number of samples, then hold the result
// until the readout side takes it.
module corr_stage_ctrl
    import corr_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] int_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dl_clr,
    output logic             dl_stall,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic             busy,
    output logic             done
);

    localparam int                FILL_W     = fill_width(DEPTH);
    localparam logic [FILL_W-1:0] FILL_LIMIT = FILL_W'(DEPTH);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] len_reg;
    logic             dl_clr_reg;
    logic             acc_clr_reg;
    logic             dump_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic abort_hit;
    logic accept;
    logic fill_en;
    logic fill_clr;
    logic fill_last;
    logic integ_clr;
    logic integ_last;
    logic dump_fire;

    // Abort only means something once a run is in progress.
    assign abort_hit = abort && (state_reg != ST_IDLE);

    // Combinational handshake: accept in FILL/INTEG unless aborting.
    // The delay lines advance exactly on an accepted sample, and the
    // accumulators only during INTEG, so acc_en implies !dl_stall.
    assign in_ready = ((state_reg == ST_FILL) || (state_reg == ST_INTEG)) && !abort_hit;
    assign accept   = in_ready && in_valid;
    assign dl_stall = !accept;
    assign acc_en   = accept && (state_reg == ST_INTEG);

    // A handshake that coincides with abort does not count as a dump.
    assign dump_fire = (state_reg == ST_DUMP) && dump_ready && !abort;

    // Counters are zeroed on entry (CLEAR), on abort and at their terminal
    // acceptance, so they can never wrap.
    assign fill_en   = accept && (state_reg == ST_FILL);
    assign fill_clr  = abort_hit || (state_reg == ST_CLEAR) || (fill_en && fill_last);
    assign integ_clr = abort_hit || (state_reg == ST_CLEAR) || (acc_en && integ_last);

    corr_sample_counter #(.W(FILL_W)) u_fill_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fill_clr),
        .en    (fill_en),
        .limit (FILL_LIMIT),
        .last  (fill_last)
    );

    corr_sample_counter #(.W(CNT_W)) u_integ_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (integ_clr),
        .en    (acc_en),
        .limit (len_reg),
        .last  (integ_last)
    );

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start && (int_len != '0)) state_next = ST_CLEAR;
            ST_CLEAR: state_next = (DEPTH == 0) ? ST_INTEG : ST_FILL;
            ST_FILL:  if (fill_en && fill_last) state_next = ST_INTEG;
            ST_INTEG: if (acc_en && integ_last) state_next = ST_DUMP;
            ST_DUMP:  if (dump_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_next = ST_IDLE;
        end
    end

    // State register and registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            dl_clr_reg     <= 1'b0;
            acc_clr_reg    <= 1'b0;
            dump_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dl_clr_reg     <= (state_next == ST_CLEAR) || abort_hit;
            acc_clr_reg    <= (state_next == ST_CLEAR) || abort_hit;
            dump_valid_reg <= (state_next == ST_DUMP);
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= dump_fire;
        end
    end

    // Integration length is captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start && (int_len != '0)) begin
            len_reg <= int_len;
        end
    end

    assign dl_clr     = dl_clr_reg;
    assign acc_clr    = acc_clr_reg;
    assign dump_valid = dump_valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_corr_stage_ctrl.sv
// Scoreboard bench for corr_stage_ctrl: each job pushes its expected run
// summary; a monitor accumulates what the DUT does and compares on run end.
module tb_corr_stage_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] int_len;
    logic             in_valid;
    logic             in_ready;
    logic             dl_clr;
    logic             dl_stall;
    logic             acc_clr;
    logic             acc_en;
    logic             dump_valid;
    logic             dump_ready;
    logic             busy;
    logic             done;

    corr_stage_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .int_len    (int_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dl_clr     (dl_clr),
        .dl_stall   (dl_stall),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int fill;
        int acc;
        int dv;
        int clr;
        int dn;
        int bsy;
    } rec_t;

    rec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_dl_clr", int'(dl_clr), 0);
        chk("rst_acc_clr", int'(acc_clr), 0);
        chk("rst_dl_stall", int'(dl_stall), 1);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_acc_en", int'(acc_en), 0);
        chk("rst_dump_valid", int'(dump_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
    endtask

    // Monitor: per-cycle rules plus per-run totals compared at run end.
    initial begin
        rec_t got;
        rec_t req;
        bit   busy_prev;
        busy_prev = 1'b0;
        got = '{default: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got = '{default: 0};
                busy_prev = 1'b0;
            end else begin
                chk("acc_clr_eq_dl_clr", int'(acc_clr), int'(dl_clr));
                if (acc_en) chk("acc_en_accept", int'(in_ready && in_valid && !dl_stall), 1);
                if (abort && busy) begin
                    chk("abort_in_ready", int'(in_ready), 0);
                    chk("abort_acc_en", int'(acc_en), 0);
                end else if (in_ready) begin
                    chk("stall_follows_valid", int'(dl_stall), int'(!in_valid));
                end else begin
                    chk("stall_when_not_ready", int'(dl_stall), 1);
                end
                if (!busy) chk("idle_in_ready", int'(in_ready), 0);
                if (done) chk("done_at_busy_fall", int'(busy_prev && !busy), 1);
                got.clr  += int'(dl_clr);
                got.fill += int'(in_ready && in_valid && !acc_en);
                got.acc  += int'(acc_en);
                got.dv   += int'(dump_valid);
                got.bsy  += int'(busy);
                got.dn   += int'(done);
                if (busy_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_run_end", 1, 0);
                    end else begin
                        req = exp_q.pop_front();
                        chk("fill_samples", got.fill, req.fill);
                        chk("acc_en_cycles", got.acc, req.acc);
                        chk("dump_valid_cycles", got.dv, req.dv);
                        chk("clr_pulses", got.clr, req.clr);
                        chk("done_pulses", got.dn, req.dn);
                        chk("busy_cycles", got.bsy, req.bsy);
                    end
                    $display("run end: fill=%0d acc=%0d dv=%0d clr=%0d done=%0d busy=%0d",
                             got.fill, got.acc, got.dv, got.clr, got.dn, got.bsy);
                    got = '{default: 0};
                end
                busy_prev = busy;
            end
        end
    end

    // mode 0: normal, 1: abort at INTEG sample k, 2: abort with the dump handshake.
    // pat 0: in_valid always 1, 1: alternating 1/0, 2: random ~60%.
    task automatic run_job(input int len, input int dly, input int pat, input int mode, input int k);
        bit   v[$];
        int   ones;
        int   f4;
        int   j;
        int   e;
        int   i;
        int   dv_seen;
        bit   b;
        rec_t r;
        ones = 0;
        f4 = -1;
        j = -1;
        while (ones < DEPTH + len) begin
            case (pat)
                0:       b = 1'b1;
                1:       b = (v.size() % 2 == 0);
                default: b = ($urandom_range(99) < 60);
            endcase
            v.push_back(b);
            if (b) begin
                ones++;
                if (ones == DEPTH) f4 = v.size() - 1;
                if (mode == 1 && ones == DEPTH + k + 1) j = v.size() - 1;
            end
        end
        e = v.size() - 1;
        // Reference: CLEAR cycle, one cycle per sample slot up to the last
        // needed acceptance, then the DUMP hold until the handshake.
        r.fill = DEPTH;
        if (mode == 1) begin
            r.acc = k; r.dv = 0; r.clr = 2; r.dn = 0; r.bsy = j + 2;
        end else begin
            r.acc = len; r.dv = dly + 1; r.clr = (mode == 2) ? 2 : 1;
            r.dn = (mode == 2) ? 0 : 1; r.bsy = e + dly + 3;
        end
        exp_q.push_back(r);
        $display("job: len=%0d dly=%0d pat=%0d mode=%0d k=%0d", len, dly, pat, mode, k);

        @(posedge clk); #1;
        start = 1'b1; int_len = CNT_W'(len); in_valid = 1'($urandom); dump_ready = 1'b0; abort = 1'b0;
        @(posedge clk); #1;   // CLEAR cycle: inputs must be ignored
        start = 1'b0; int_len = CNT_W'($urandom); in_valid = 1'($urandom);
        i = 0;
        dv_seen = 0;
        forever begin
            @(posedge clk); #1;
            if (!busy) break;
            if (i > 3000) begin
                chk("run_timeout", 0, 1);
                break;
            end
            in_valid = (i < v.size()) ? v[i] : 1'($urandom);
            start    = (i < f4) ? 1'($urandom) : 1'b0;
            int_len  = CNT_W'($urandom);
            abort    = (mode == 1 && i == j);
            if (dump_valid) begin
                dump_ready = (dv_seen >= dly);
                if (mode == 2 && dv_seen >= dly) abort = 1'b1;
                dv_seen++;
            end else begin
                dump_ready = 1'($urandom);
            end
            i++;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; dump_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; int_len = '0;
        in_valid = 1'b0; dump_ready = 1'b0;
        #2;
        check_reset_vals();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Abort in IDLE and start with zero length: nothing happens.
        @(posedge clk); #1;
        start = 1'b1; int_len = '0; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("zero_len_busy", int'(busy), 0);
            chk("zero_len_clr", int'(dl_clr), 0);
            @(posedge clk); #1;
        end

        run_job(5, 0, 0, 0, 0);     // continuous run
        run_job(3, 0, 1, 0, 0);     // alternating gaps
        run_job(4, 10, 0, 0, 0);    // dump backpressure
        run_job(6, 0, 0, 1, 2);     // abort at INTEG sample 2
        run_job(2, 0, 0, 0, 0);     // normal run after abort
        run_job(3, 2, 2, 2, 0);     // abort together with dump handshake
        run_job(255, 0, 0, 0, 0);   // maximum length

        // Asynchronous reset mid-INTEG, between clock edges.
        @(posedge clk); #1;
        start = 1'b1; int_len = CNT_W'(10); in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen < 2; c++) begin
            @(posedge clk); #1;
            if (acc_en) seen++;
        end
        chk("reached_integ", seen, 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        run_job(3, 1, 0, 0, 0);     // next start begins with CLEAR

        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(1, 20);
            run_job(len, $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, len - 1));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
